// File: rtl/effect_bypass_ctrl.sv
// -----------------------------------------------------------------------------
// effect_bypass_ctrl
//
// Click-free bypass controller for the guitar effect chain.
//
// The footswitch is synchronised into the bit-clock domain and debounced in
// units of stereo frames. Each accepted press starts (or reverses) a linear
// crossfade between the dry path and the effect path. All gain updates are
// aligned to the start of the left word, so both channels of a frame always
// see the same wet/dry pair and the mixer never sees a mid-frame step.
//
// Parameters
//   DEBOUNCE_FRAMES  frames the synchronised footswitch must differ from the
//                    stable level before the new level is accepted (1..65535)
//   RAMP_STEPS       frames per full crossfade, power of two (1..256)
//
// Ports
//   clk             bit clock (BCK); all logic on the rising edge
//   rst             synchronous active-high reset
//   i_lrck          I2S word select (0 = left), sampled on clk
//   i_footswitch    raw asynchronous footswitch level, active-high press
//   i_force_bypass  level; forces the dry path on the next edge
//   o_wet_gain      effect gain, unsigned Q1.8 (256 = 1.0)
//   o_dry_gain      dry gain, always 256 - o_wet_gain
//   o_effect_on     high in FADE_IN, ACTIVE and FADE_OUT
//   o_state         0 BYPASS, 1 FADE_IN, 2 ACTIVE, 3 FADE_OUT
//   o_frame_tick    one-cycle pulse per frame start
//   o_toggle        one-cycle pulse per accepted footswitch press
// -----------------------------------------------------------------------------
module effect_bypass_ctrl #(
  parameter int DEBOUNCE_FRAMES = 480,
  parameter int RAMP_STEPS      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lrck,
  input  logic       i_footswitch,
  input  logic       i_force_bypass,
  output logic [8:0] o_wet_gain,
  output logic [8:0] o_dry_gain,
  output logic       o_effect_on,
  output logic [1:0] o_state,
  output logic       o_frame_tick,
  output logic       o_toggle
);

  localparam int SYNC_STAGES = 2;
  localparam int STEP        = 256 / RAMP_STEPS;

  // Ramp arithmetic is done one bit wider than the gain so that wet + STEP
  // (at most 256 + 256) never wraps before saturation.
  localparam logic [9:0]  STEP_W    = 10'(STEP);
  localparam logic [9:0]  UNITY_W   = 10'd256;
  localparam logic [16:0] DB_TARGET = 17'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    ST_BYPASS   = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Frame tick: falling edge of LRCK marks the start of the left word.
  // lrck_prev resets low, so the first tick needs LRCK seen high then low.
  // ---------------------------------------------------------------------------
  logic lrck_prev_reg;
  logic frame_tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_prev_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      lrck_prev_reg  <= i_lrck;
      frame_tick_reg <= lrck_prev_reg & ~i_lrck;
    end
  end

  // ---------------------------------------------------------------------------
  // Footswitch synchroniser. Stage 0 captures the asynchronous pin; each later
  // stage re-registers the previous one.
  // ---------------------------------------------------------------------------
  logic sync_stage_reg [SYNC_STAGES];
  logic fs_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_stage_reg[gi] <= 1'b0;
          else     sync_stage_reg[gi] <= i_footswitch;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) sync_stage_reg[gi] <= 1'b0;
          else     sync_stage_reg[gi] <= sync_stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign fs_s = sync_stage_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame-rate debounce. The counter only advances on ticks, so its unit is a
  // frame rather than a clock. Any frame where the input agrees with the
  // stable level restarts the count, which rejects bounce. Only a newly
  // accepted high level produces a toggle; releases are silent.
  // ---------------------------------------------------------------------------
  logic        fs_stable_reg;
  logic [15:0] cnt_reg;
  logic        toggle_reg;
  logic        db_expired;

  assign db_expired = ({1'b0, cnt_reg} + 17'd1) == DB_TARGET;

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_stable_reg <= 1'b0;
      cnt_reg       <= 16'd0;
      toggle_reg    <= 1'b0;
    end else begin
      toggle_reg <= 1'b0;
      if (frame_tick_reg) begin
        if (fs_s != fs_stable_reg) begin
          if (db_expired) begin
            fs_stable_reg <= fs_s;
            cnt_reg       <= 16'd0;
            toggle_reg    <= fs_s;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end else begin
          cnt_reg <= 16'd0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Crossfade state machine: state register.
  // The wet gain is held alongside the state because ramp completion and the
  // state change land on the same edge.
  // ---------------------------------------------------------------------------
  state_t     state_reg;
  state_t     state_next;
  logic [8:0] wet_reg;
  logic [8:0] wet_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_BYPASS;
      wet_reg   <= 9'd0;
    end else begin
      state_reg <= state_next;
      wet_reg   <= wet_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // A toggle is resolved first into an intermediate direction, and a tick on
  // the same edge then ramps in that new direction. Reversals keep the current
  // gain, so a press mid-fade turns around without a jump.
  // ---------------------------------------------------------------------------
  state_t     state_dir;
  logic [9:0] wet_up;
  logic [9:0] wet_ext;

  assign wet_ext = {1'b0, wet_reg};
  assign wet_up  = wet_ext + STEP_W;

  always_comb begin
    state_dir  = state_reg;
    state_next = state_reg;
    wet_next   = wet_reg;

    if (i_force_bypass) begin
      // Overrides toggles and ticks; the debounce keeps tracking regardless.
      state_next = ST_BYPASS;
      wet_next   = 9'd0;
    end else begin
      if (toggle_reg) begin
        unique case (state_reg)
          ST_BYPASS, ST_FADE_OUT: state_dir = ST_FADE_IN;
          ST_ACTIVE, ST_FADE_IN:  state_dir = ST_FADE_OUT;
          default:                state_dir = state_reg;
        endcase
      end
      state_next = state_dir;

      if (frame_tick_reg) begin
        unique case (state_dir)
          ST_FADE_IN: begin
            if (wet_up >= UNITY_W) begin
              wet_next   = 9'd256;
              state_next = ST_ACTIVE;
            end else begin
              wet_next = wet_up[8:0];
            end
          end
          ST_FADE_OUT: begin
            if (wet_ext <= STEP_W) begin
              wet_next   = 9'd0;
              state_next = ST_BYPASS;
            end else begin
              wet_next = 9'(wet_ext - STEP_W);
            end
          end
          default: begin
            wet_next = wet_reg;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Dry gain is derived rather than stored so the pair always sums
  // to unity on every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_state      = state_reg;
    o_effect_on  = (state_reg != ST_BYPASS);
    o_wet_gain   = wet_reg;
    o_dry_gain   = 9'd256 - wet_reg;
    o_frame_tick = frame_tick_reg;
    o_toggle     = toggle_reg;
  end

endmodule

// File: tb/tb_effect_bypass_ctrl.sv
// -----------------------------------------------------------------------------
// tb_effect_bypass_ctrl
//
// Two instances share all inputs: one with a 4-frame debounce and one with a
// 1-frame debounce (so a reversal mid-fade can be produced), both with a
// 4-step ramp and a 64-clock frame. A behavioural model predicts the outputs
// of each instance per clock and pushes them into a queue; a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_effect_bypass_ctrl;

  localparam int FRAME = 64;
  localparam int RS    = 4;
  localparam int STEP  = 256 / RS;
  localparam int DB_A  = 4;
  localparam int DB_B  = 1;

  logic clk;
  logic rst;
  logic lrck;
  logic fs;
  logic force_bp;

  logic [8:0] wet_a, dry_a, wet_b, dry_b;
  logic [1:0] st_a, st_b;
  logic       eff_a, eff_b, tick_a, tick_b, tog_a, tog_b;

  effect_bypass_ctrl #(.DEBOUNCE_FRAMES(DB_A), .RAMP_STEPS(RS)) dut_a (
    .clk(clk), .rst(rst), .i_lrck(lrck), .i_footswitch(fs),
    .i_force_bypass(force_bp),
    .o_wet_gain(wet_a), .o_dry_gain(dry_a), .o_effect_on(eff_a),
    .o_state(st_a), .o_frame_tick(tick_a), .o_toggle(tog_a)
  );

  effect_bypass_ctrl #(.DEBOUNCE_FRAMES(DB_B), .RAMP_STEPS(RS)) dut_b (
    .clk(clk), .rst(rst), .i_lrck(lrck), .i_footswitch(fs),
    .i_force_bypass(force_bp),
    .o_wet_gain(wet_b), .o_dry_gain(dry_b), .o_effect_on(eff_b),
    .o_state(st_b), .o_frame_tick(tick_b), .o_toggle(tog_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: integer bookkeeping of the documented rules.
  // mode: 0 bypass, 1 fading in, 2 active, 3 fading out.
  // ---------------------------------------------------------------------------
  typedef struct {
    int lrck_prev;
    int tick;
    int sync1;
    int sync2;
    int stable;
    int cnt;
    int toggle;
    int mode;
    int wet;
  } mdl_t;

  typedef struct {
    int wet;
    int mode;
    int tick;
    int toggle;
  } exp_t;

  mdl_t ma, mb;
  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   toggles_seen_a = 0;
  int   toggles_seen_b = 0;

  function automatic mdl_t model_step(mdl_t m, int db, bit r, bit lr, bit f, bit frc);
    mdl_t n;
    int   mode;
    int   wet;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    // frame start = LRCK seen high then low
    n.tick      = (m.lrck_prev == 1 && lr == 1'b0) ? 1 : 0;
    n.lrck_prev = lr ? 1 : 0;
    n.sync1     = f ? 1 : 0;
    n.sync2     = m.sync1;
    n.toggle    = 0;
    if (m.tick == 1) begin
      if (m.sync2 != m.stable) begin
        if (m.cnt + 1 == db) begin
          n.stable = m.sync2;
          n.cnt    = 0;
          n.toggle = m.sync2;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end else begin
        n.cnt = 0;
      end
    end
    if (frc) begin
      n.mode = 0;
      n.wet  = 0;
    end else begin
      mode = m.mode;
      wet  = m.wet;
      if (m.toggle == 1)
        mode = (mode == 0 || mode == 3) ? 1 : 3;
      if (m.tick == 1) begin
        if (mode == 1) begin
          wet = (wet + STEP > 256) ? 256 : wet + STEP;
          if (wet == 256) mode = 2;
        end else if (mode == 3) begin
          wet = (wet - STEP < 0) ? 0 : wet - STEP;
          if (wet == 0) mode = 0;
        end
      end
      n.mode = mode;
      n.wet  = wet;
    end
    return n;
  endfunction

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
  end

  always @(posedge clk) begin
    exp_t e;
    ma = model_step(ma, DB_A, rst, lrck, fs, force_bp);
    mb = model_step(mb, DB_B, rst, lrck, fs, force_bp);
    e = '{ma.wet, ma.mode, ma.tick, ma.toggle};
    q_a.push_back(e);
    e = '{mb.wet, mb.mode, mb.tick, mb.toggle};
    q_b.push_back(e);
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic check_dut(input string name, input exp_t e,
                           input logic [8:0] wet, input logic [8:0] dry,
                           input logic [1:0] st, input logic eff,
                           input logic tick, input logic tog);
    logic [8:0] ew, ed;
    logic [1:0] es;
    logic       ee, et, eg;
    ew = 9'(e.wet);
    ed = 9'(256 - e.wet);
    es = 2'(e.mode);
    ee = (e.mode != 0);
    et = (e.tick != 0);
    eg = (e.toggle != 0);
    checks++;
    if (wet !== ew || dry !== ed || st !== es || eff !== ee ||
        tick !== et || tog !== eg) begin
      errors++;
      $display("FAIL %s cyc=%0d got wet=%0d dry=%0d st=%0d eff=%b tick=%b tog=%b expected wet=%0d dry=%0d st=%0d eff=%b tick=%b tog=%b",
               name, cyc, wet, dry, st, eff, tick, tog, ew, ed, es, ee, et, eg);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d got qa=%0d qb=%0d expected nonzero",
               cyc, q_a.size(), q_b.size());
    end else begin
      e = q_a.pop_front();
      check_dut("dut_a", e, wet_a, dry_a, st_a, eff_a, tick_a, tog_a);
      e = q_b.pop_front();
      check_dut("dut_b", e, wet_b, dry_b, st_b, eff_b, tick_b, tog_b);
      if (tog_a === 1'b1) toggles_seen_a++;
      if (tog_b === 1'b1) toggles_seen_b++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    lrck = 1'b0;
    forever begin
      for (int p = 0; p < FRAME; p++) begin
        @(negedge clk);
        lrck = (p >= FRAME / 2);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    wait_cycles(n * FRAME);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    fs       = 1'b0;
    force_bp = 1'b0;
    wait_cycles(3);
    rst = 1'b0;

    // idle: ticks only
    frames(3);

    // clean press, held then released, ends ACTIVE
    fs = 1'b1; frames(10);
    fs = 1'b0; frames(12);

    // bounce: toggling every 20 clocks for about 3 frames
    for (int i = 0; i < 10; i++) begin
      fs = ~fs;
      wait_cycles(20);
    end
    fs = 1'b0; frames(5);

    // press from ACTIVE fades out to bypass
    fs = 1'b1; frames(6);
    fs = 1'b0; frames(10);

    // rapid press/release/press: reverses the 1-frame-debounce instance mid-fade
    fs = 1'b1; frames(1);
    fs = 1'b0; frames(1);
    fs = 1'b1; frames(1);
    fs = 1'b0; frames(10);

    // get to ACTIVE, then force bypass mid-frame with a press while held
    fs = 1'b1; frames(6);
    fs = 1'b0; frames(10);
    wait_cycles($urandom_range(10, 50));
    force_bp = 1'b1;
    fs = 1'b1; frames(6);
    fs = 1'b0; frames(6);
    force_bp = 1'b0;
    frames(4);

    // reset in the middle of a fade
    fs = 1'b1; frames(6);
    fs = 1'b0; frames(10);
    fs = 1'b1; frames(5);
    wait_cycles(FRAME + $urandom_range(0, 40));
    pulse_reset();
    fs = 1'b0; frames(8);

    // randomized footswitch, force and occasional reset
    for (int i = 0; i < 80; i++) begin
      fs       = 1'($urandom_range(0, 1));
      force_bp = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) pulse_reset();
      wait_cycles($urandom_range(20, 130));
    end

    force_bp = 1'b0;
    fs       = 1'b0;
    frames(2);
    @(negedge clk);
    #1;
    checks++;
    if (toggles_seen_a == 0 || toggles_seen_b == 0) begin
      errors++;
      $display("FAIL toggle_activity got a=%0d b=%0d expected both nonzero",
               toggles_seen_a, toggles_seen_b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
